// File: rtl/display_scan_driver.sv
// -----------------------------------------------------------------------------
// display_scan_driver
//
// Time-multiplexes a packed multi-digit hex value onto a common-segment
// display, one digit per scan slot. Each slot lasts TICK_DIV cycles. The
// first BLANK_CYCLES cycles of a slot are dark to suppress ghosting, and the
// selected digit is shown for the rest of the slot. The displayed value is
// double buffered: a load taken during a scan is held in a pending register
// and only takes effect at the frame boundary, so a frame never tears.
//
// Optional feature (macro LEADING_ZERO_BLANK_EN): leading zero digits above
// the most-significant nonzero nibble stay dark. Digit 0 is always shown.
//
// Parameters:
//   DIGITS        number of digits scanned (1..8)
//   TICK_DIV      clock cycles per digit slot (>= 2)
//   BLANK_CYCLES  dark cycles at the start of each slot (< TICK_DIV)
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   enable        scan enable; low forces idle/dark
//   load          single-cycle strobe that captures value
//   value         packed nibbles, digit k = value[4k+3:4k], digit 0 rightmost
//   digit_onehot  one-hot code of the displayed nibble, 0 when dark
//   anode         active-high one-hot digit select, 0 when dark
//   frame_done    one-cycle pulse in the last cycle of the final digit slot
// -----------------------------------------------------------------------------
module display_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int TICK_DIV     = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  output logic [15:0]           digit_onehot,
  output logic [DIGITS-1:0]     anode,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic [CNT_W:0]   BLANK_END = (CNT_W+1)'(BLANK_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   pending_q, pending_d;
  logic                  pending_valid_q, pending_valid_d;
  logic                  boundary_s;

  logic [15:0]           digit_onehot_d;
  logic [DIGITS-1:0]     anode_d;
  logic                  frame_done_d;
  logic [3:0]            nibble_s;
  logic                  show_s;

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the most-significant nonzero nibble; 0 when the value is zero,
  // which keeps digit 0 visible.
  function automatic logic [IDX_W-1:0] msnz_idx(input logic [4*DIGITS-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (v[4*k +: 4] != 4'h0) r = IDX_W'(k);
    end
    return r;
  endfunction
`endif

  // State, counters and display buffers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      div_cnt_q       <= '0;
      idx_q           <= '0;
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      div_cnt_q       <= div_cnt_d;
      idx_q           <= idx_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
    end
  end

  // Next state: slot counter, digit index, and double-buffer update.
  always_comb begin
    state_d         = state_q;
    div_cnt_d       = div_cnt_q;
    idx_d           = idx_q;
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;

    boundary_s = (state_q != IDLE) && (idx_q == IDX_LAST) && (div_cnt_q == CNT_LAST);

    if (!enable) begin
      state_d   = IDLE;
      div_cnt_d = '0;
      idx_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          div_cnt_d = '0;
          idx_d     = '0;
        end
        BLANK, SHOW: begin
          if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
            idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
          end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          div_cnt_d = '0;
          idx_d     = '0;
        end
      endcase
      state_d = ({1'b0, div_cnt_d} < BLANK_END) ? BLANK : SHOW;
    end

    // A load in IDLE or exactly at the frame boundary goes straight to the
    // shadow and supersedes anything pending.
    if (load && ((state_q == IDLE) || boundary_s)) begin
      shadow_d        = value;
      pending_valid_d = 1'b0;
    end else if (load) begin
      pending_d       = value;
      pending_valid_d = 1'b1;
    end else if (boundary_s && pending_valid_q) begin
      shadow_d        = pending_q;
      pending_valid_d = 1'b0;
    end else begin
      pending_valid_d = pending_valid_q;
    end
  end

  // Output decode from next-state values so the registered outputs line up
  // with the state they describe, without an extra cycle of latency.
  always_comb begin
    anode_d        = '0;
    digit_onehot_d = '0;
    nibble_s       = shadow_d[{idx_d, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    show_s         = (idx_d <= msnz_idx(shadow_d));
`else
    show_s         = 1'b1;
`endif
    if ((state_d == SHOW) && show_s) begin
      anode_d        = DIGITS'(1) << idx_d;
      digit_onehot_d = 16'd1 << nibble_s;
    end else begin
      anode_d        = '0;
      digit_onehot_d = '0;
    end
    frame_done_d = (state_d != IDLE) && (idx_d == IDX_LAST) && (div_cnt_d == CNT_LAST);
  end

  // Registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      anode        <= '0;
      digit_onehot <= '0;
      frame_done   <= 1'b0;
    end else begin
      anode        <= anode_d;
      digit_onehot <= digit_onehot_d;
      frame_done   <= frame_done_d;
    end
  end

endmodule
